conv_layer_sequencer: RTL
=========================

# conv_layer_sequencer

Sequences the convolution engine (`convolution_top_CU` plus its kernel/window/output BRAMs) through a host-programmed list of layers, one output channel at a time. It holds a small descriptor table and drives the engine's `Image_size`, `Channel_size` and `Load_kernel_BRAM` inputs. It handshakes with the kernel-loading DMA and detects end-of-pass from the engine's output stream. It sits between the AXI-Lite register block and the convolution top.

## Interface

Parameters:
- `MAX_LAYERS`, default 8: descriptor table depth (power of two).
- `LIDX_W`, default 3: log2(`MAX_LAYERS`).

Ports:
- `clk` in 1: the single clock.
- `aresetn` in 1: reset, synchronous and active-low.
- `cfg_we` in 1: descriptor write strobe.
- `cfg_addr` in `LIDX_W`: descriptor index.
- `cfg_image_size` in 8: H=W for the layer.
- `cfg_channel_size` in 9: input channels for the layer.
- `cfg_out_channels` in 9: output channels for the layer.
- `cfg_num_layers` in `LIDX_W+1`: layers to run; sampled on `start`.
- `start` in 1: begin the sequence; level-sampled in idle.
- `abort` in 1: synchronous abort.
- `kernel_load_done` in 1: DMA pulse; kernel BRAM filled for the current output channel.
- `m_axis_tvalid`, `m_axis_tready`, `m_axis_tlast` in 1 each: taps on the engine output stream.
- `Load_kernel_BRAM` out 1: to the engine; high while the kernel DMA runs.
- `kernel_load_req` out 1: to the DMA; same timing as `Load_kernel_BRAM`.
- `Image_size` out 8, `Channel_size` out 9: registered layer configuration.
- `layer_idx` out `LIDX_W`: current layer.
- `out_ch_idx` out 9: current output channel; the DMA uses it for kernel addressing.
- `busy` out 1, `done` out 1 (one-cycle pulse), `cfg_err` out 1 (sticky).

## Operation

- **Descriptor table:** `MAX_LAYERS` entries of {image, channel, out_channels}, 26 bits each. A write occurs on `cfg_we` only while in `S_Idle`; writes in other states are dropped. Reset clears the table.
- **State machine (Moore, registered outputs):**
  - `S_Reset` → `S_Idle`.
  - `S_Idle`:
    - `start` with `cfg_num_layers`==0 → `S_Done`.
    - `start` otherwise → `S_Fetch`; latches num_layers, clears `layer_idx` and `out_ch_idx`.
  - `S_Fetch`: loads `Image_size`/`Channel_size` from entry `layer_idx`, then → `S_Load`.
  - `S_Load`: `Load_kernel_BRAM`=`kernel_load_req`=1. Stays until `kernel_load_done`, then → `S_Run`.
  - `S_Run`: waits for `m_axis_tvalid & m_axis_tready & m_axis_tlast`.
    - If `out_ch_idx`==out_channels-1 (9-bit compare) → `S_Next_layer`.
    - Otherwise → `S_Next_och`.
  - `S_Next_och`: `out_ch_idx`++, then → `S_Load`.
  - `S_Next_layer`:
    - If `layer_idx`==num_layers-1 → `S_Done`.
    - Otherwise `layer_idx`++, `out_ch_idx`←0, → `S_Fetch`.
  - `S_Done`: `done`=1, then → `S_Idle`.
- `busy`=1 in every state except `S_Reset`, `S_Idle` and `S_Done`.
- `abort`, sampled in any state other than `S_Reset` or `S_Idle`, → `S_Idle` on the next edge. `Load_kernel_BRAM` drops in the same edge. No `done` pulse is generated.
- **Precedence within a cycle:** `aresetn` > `abort` > `kernel_load_done`/tlast.
- `kernel_load_done` outside `S_Load` and tlast beats outside `S_Run` are ignored.
- `start` in `S_Idle` together with `cfg_we`: the write lands and `S_Fetch` reads the new value.
- `out_channels`==0 with checking compiled out: the compare against 511 yields 512 passes.

## Timing

- Reset values:
  - State `S_Reset`.
  - All outputs 0: `Image_size`, `Channel_size`, `layer_idx`, `out_ch_idx`, `busy`, `done`, `cfg_err`, `Load_kernel_BRAM`, `kernel_load_req`.
- Latency:
  - `start` sampled at edge k → `busy`=1 after k.
  - `Load_kernel_BRAM`=1 after k+1.
  - `kernel_load_done` at edge j → `Load_kernel_BRAM`=0 after j.
  - Last tlast beat at edge t → next `Load_kernel_BRAM`=1 after t+1 (same layer) or t+2 (new layer).
- `Load_kernel_BRAM` is high for at least one full cycle per pass, as the engine's idle-to-loading transition requires.
- `Image_size`/`Channel_size` change only in `S_Fetch`, never while the engine is streaming.

## Configuration

- `CONV_SEQ_CFG_CHECK_EN` defined:
  - `S_Fetch` validates the entry: image ∈ {4,8,16,32,64,128}, channel ∈ {64,128,256}, out_channels≠0.
  - On failure: `cfg_err`←1 (sticky until reset or next `start`), → `S_Idle`, no `done`.
- `CONV_SEQ_CFG_CHECK_EN` undefined: no checking; `cfg_err` is tied to 0.

## Structure

- Package `conv_seq_pkg`: state encoding localparams (5-bit, `S_`-prefixed), legal image/channel size constants, descriptor field widths.
- Sub-module `conv_seq_desc_table`: synchronous-write, combinational-read descriptor register file, with reset clear and write gating by an `allow_wr` input.

## Test plan

1. Program entry0 = {8,64,2}, num_layers=1, start. Expect two `Load_kernel_BRAM` windows, `out_ch_idx` 0 then 1. After the second tlast, `done` pulses exactly 2 cycles after that tlast beat.
2. Program entries {4,256,1} and {16,128,1}, num_layers=2. Expect `Image_size` 4→16 and `Channel_size` 256→128 in `S_Fetch`, `layer_idx` 0→1, then a single `done`.
3. Hold `kernel_load_done` low for 50 cycles. Expect `Load_kernel_BRAM` held high. Then give tlast with `m_axis_tready`=0. Expect no advance until `tready`=1.
4. Assert `abort` in `S_Run` in the same cycle as tlast. Expect `S_Idle` and `busy`=0 next cycle, no `done`. Then pull `aresetn` low mid-`S_Load`. Expect all outputs 0 next edge.
5. With `CONV_SEQ_CFG_CHECK_EN`, entry {12,64,1}. Expect `cfg_err`=1, no `Load_kernel_BRAM`. Without the macro, the same entry runs normally.
6. Start with `cfg_num_layers`=0. Expect `done` 1 cycle after `start`, `Load_kernel_BRAM` never asserted. Issue `cfg_we` while `busy`. Expect the table unchanged.

Source files
------------

// File: rtl/conv_seq_pkg.sv
// Shared definitions for the convolution layer sequencer: state encoding,
// descriptor layout and the legal-geometry check used when CONV_SEQ_CFG_CHECK_EN is defined.
package conv_seq_pkg;

  localparam int IMG_W  = 8;
  localparam int CH_W   = 9;
  localparam int OCH_W  = 9;
  localparam int DESC_W = IMG_W + CH_W + OCH_W;

  typedef logic [4:0] state_t;

  localparam state_t S_RESET      = 5'd0;
  localparam state_t S_IDLE       = 5'd1;
  localparam state_t S_FETCH      = 5'd2;
  localparam state_t S_LOAD       = 5'd3;
  localparam state_t S_RUN        = 5'd4;
  localparam state_t S_NEXT_OCH   = 5'd5;
  localparam state_t S_NEXT_LAYER = 5'd6;
  localparam state_t S_DONE       = 5'd7;

  localparam logic [IMG_W-1:0] IMG_4   = 8'd4;
  localparam logic [IMG_W-1:0] IMG_8   = 8'd8;
  localparam logic [IMG_W-1:0] IMG_16  = 8'd16;
  localparam logic [IMG_W-1:0] IMG_32  = 8'd32;
  localparam logic [IMG_W-1:0] IMG_64  = 8'd64;
  localparam logic [IMG_W-1:0] IMG_128 = 8'd128;

  localparam logic [CH_W-1:0] CH_64  = 9'd64;
  localparam logic [CH_W-1:0] CH_128 = 9'd128;
  localparam logic [CH_W-1:0] CH_256 = 9'd256;

  typedef struct packed {
    logic [IMG_W-1:0] image;
    logic [CH_W-1:0]  channel;
    logic [OCH_W-1:0] out_channels;
  } desc_t;

  // Geometries the engine's line buffers and BRAM layout actually support.
  function automatic logic desc_legal(input desc_t d);
    logic img_ok;
    logic ch_ok;
    img_ok = (d.image == IMG_4)  || (d.image == IMG_8)  || (d.image == IMG_16) ||
             (d.image == IMG_32) || (d.image == IMG_64) || (d.image == IMG_128);
    ch_ok  = (d.channel == CH_64) || (d.channel == CH_128) || (d.channel == CH_256);
    return img_ok && ch_ok && (d.out_channels != '0);
  endfunction

endpackage

// File: rtl/conv_seq_desc_table.sv
// Layer descriptor register file: synchronous write gated by allow_wr,
// combinational read, cleared on reset.
module conv_seq_desc_table
  import conv_seq_pkg::*;
#(
  parameter int MAX_LAYERS = 8,
  parameter int LIDX_W     = 3
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              allow_wr,
  input  logic              we,
  input  logic [LIDX_W-1:0] waddr,
  input  desc_t             wdata,
  input  logic [LIDX_W-1:0] raddr,
  output desc_t             rdata
);

  desc_t table_q [MAX_LAYERS];

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      for (int i = 0; i < MAX_LAYERS; i++) table_q[i] <= '0;
    end else if (we && allow_wr) begin
      table_q[waddr] <= wdata;
    end
  end

  assign rdata = table_q[raddr];

endmodule

// File: rtl/conv_layer_sequencer.sv
// Steps the convolution engine through programmed layers, one output channel
// per pass. Optional descriptor validation: define CONV_SEQ_CFG_CHECK_EN.
module conv_layer_sequencer
  import conv_seq_pkg::*;
#(
  parameter int MAX_LAYERS = 8,
  parameter int LIDX_W     = 3
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              cfg_we,
  input  logic [LIDX_W-1:0] cfg_addr,
  input  logic [7:0]        cfg_image_size,
  input  logic [8:0]        cfg_channel_size,
  input  logic [8:0]        cfg_out_channels,
  input  logic [LIDX_W:0]   cfg_num_layers,
  input  logic              start,
  input  logic              abort,
  input  logic              kernel_load_done,
  input  logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  input  logic              m_axis_tlast,
  output logic              Load_kernel_BRAM,
  output logic              kernel_load_req,
  output logic [7:0]        Image_size,
  output logic [8:0]        Channel_size,
  output logic [LIDX_W-1:0] layer_idx,
  output logic [8:0]        out_ch_idx,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  state_t          state;
  state_t          state_nxt;
  desc_t           wr_desc;
  desc_t           entry;
  logic [LIDX_W:0] num_layers;
  logic            entry_ok;
  logic            beat;
  logic            last_och;
  logic            last_layer;
  logic            abort_act;
  logic            load_nxt;
  logic            busy_nxt;
  logic            done_nxt;

  assign wr_desc = '{image: cfg_image_size, channel: cfg_channel_size,
                     out_channels: cfg_out_channels};

  conv_seq_desc_table #(
    .MAX_LAYERS (MAX_LAYERS),
    .LIDX_W     (LIDX_W)
  ) u_desc_table (
    .clk      (clk),
    .aresetn  (aresetn),
    .allow_wr (state == S_IDLE),
    .we       (cfg_we),
    .waddr    (cfg_addr),
    .wdata    (wr_desc),
    .raddr    (layer_idx),
    .rdata    (entry)
  );

`ifdef CONV_SEQ_CFG_CHECK_EN
  assign entry_ok = desc_legal(entry);
`else
  assign entry_ok = 1'b1;
`endif

  assign beat      = m_axis_tvalid & m_axis_tready & m_axis_tlast;
  // out_channels==0 wraps to 511 here, giving a full 512-pass layer.
  assign last_och   = (out_ch_idx == entry.out_channels - 9'd1);
  assign last_layer = ({1'b0, layer_idx} == num_layers - (LIDX_W+1)'(1));
  assign abort_act  = abort && (state != S_RESET) && (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state            <= S_RESET;
      Load_kernel_BRAM <= 1'b0;
      kernel_load_req  <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      state            <= state_nxt;
      Load_kernel_BRAM <= load_nxt;
      kernel_load_req  <= load_nxt;
      busy             <= busy_nxt;
      done             <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RESET:      state_nxt = S_IDLE;
      S_IDLE:       if (start) state_nxt = (cfg_num_layers == '0) ? S_DONE : S_FETCH;
      S_FETCH:      state_nxt = entry_ok ? S_LOAD : S_IDLE;
      S_LOAD:       if (kernel_load_done) state_nxt = S_RUN;
      S_RUN:        if (beat) state_nxt = last_och ? S_NEXT_LAYER : S_NEXT_OCH;
      S_NEXT_OCH:   state_nxt = S_LOAD;
      S_NEXT_LAYER: state_nxt = last_layer ? S_DONE : S_FETCH;
      S_DONE:       state_nxt = S_IDLE;
      default:      state_nxt = S_IDLE;
    endcase
    if (abort_act) state_nxt = S_IDLE;
  end

  // Outputs are decoded from the next state and registered alongside it.
  always_comb begin
    load_nxt = 1'b0;
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    case (state_nxt)
      S_FETCH, S_RUN, S_NEXT_OCH, S_NEXT_LAYER: busy_nxt = 1'b1;
      S_LOAD: begin
        busy_nxt = 1'b1;
        load_nxt = 1'b1;
      end
      S_DONE:  done_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      num_layers   <= '0;
      layer_idx    <= '0;
      out_ch_idx   <= '0;
      Image_size   <= '0;
      Channel_size <= '0;
    end else if (!abort_act) begin
      case (state)
        S_IDLE: begin
          if (start) begin
            num_layers <= cfg_num_layers;
            layer_idx  <= '0;
            out_ch_idx <= '0;
          end
        end
        S_FETCH: begin
          if (entry_ok) begin
            Image_size   <= entry.image;
            Channel_size <= entry.channel;
          end
        end
        S_NEXT_OCH: out_ch_idx <= out_ch_idx + 9'd1;
        S_NEXT_LAYER: begin
          if (!last_layer) begin
            layer_idx  <= layer_idx + LIDX_W'(1);
            out_ch_idx <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CONV_SEQ_CFG_CHECK_EN
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      cfg_err <= 1'b0;
    end else if (state == S_IDLE && start) begin
      cfg_err <= 1'b0;
    end else if (state == S_FETCH && !abort && !entry_ok) begin
      cfg_err <= 1'b1;
    end
  end
`else
  assign cfg_err = 1'b0;
`endif

endmodule
